pc_fetch_ctrl: RTL

//  Program-counter register and instruction-fetch sequencer; consumes the 3-bit PC_SOURCE select from the

---
 rtl/pc_fetch_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter register and single-outstanding instruction
// fetch sequencer. Issues one fetch per instruction on a req/gnt/rvalid port
// and holds the fetched word until the control unit strobes pc_write_i.
//
// Optional build macro: FETCH_MISALIGN_CHK_EN
//   defined     -> misaligned targets raise misalign_err_o and park the block
//                  in S_HOLD until an aligned trap-vector/trap-return redirect.
//   not defined -> the low two bits of every loaded PC are forced to zero.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  pc_source_i,
    input  logic        pc_write_i,
    input  logic [31:0] jalr_tgt_i,
    input  logic [31:0] branch_tgt_i,
    input  logic [31:0] jal_tgt_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] ir_o,
    output logic        ir_valid_o
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        misalign_err_o
`endif
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic        ir_valid_q;
    logic        imem_req_q;
    logic [31:0] pc_plus4_d;
    logic [31:0] target_d;
    logic [31:0] next_pc_d;

    assign pc_plus4_d = pc_q + 32'd4;

    // Raw redirect target chosen by the decoder's select; unused codes fall through to PC+4
    always_comb begin
        target_d = pc_plus4_d;
        case (pc_source_i)
            3'b001:  target_d = jalr_tgt_i;
            3'b010:  target_d = branch_tgt_i;
            3'b011:  target_d = jal_tgt_i;
            3'b100:  target_d = mtvec_i;
            3'b101:  target_d = mepc_i;
            default: target_d = pc_plus4_d;
        endcase
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_err_q;
    logic misaligned_d;
    logic trap_src_d;

    // Targets are loaded untouched so the faulting address stays visible in pc_o
    always_comb begin
        next_pc_d    = target_d;
        misaligned_d = (target_d[1:0] != 2'b00);
        trap_src_d   = (pc_source_i == 3'b100) || (pc_source_i == 3'b101);
    end

    assign misalign_err_o = misalign_err_q;
`else
    // Without the checker, word alignment is simply enforced on every load
    always_comb begin
        next_pc_d = target_d & ~32'h0000_0003;
    end
`endif

    // Fetch sequencer: BOOT -> REQ -> WAIT -> HOLD, one instruction in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= S_BOOT;
            pc_q           <= RESET_VEC;
            ir_q           <= NOP_INSTR;
            ir_valid_q     <= 1'b0;
            imem_req_q     <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_BOOT: begin
                    state_q    <= S_REQ;
                    imem_req_q <= 1'b1;
                end
                S_REQ: begin
                    // Request stays up until the memory accepts it
                    if (imem_gnt_i) begin
                        state_q    <= S_WAIT;
                        imem_req_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        state_q    <= S_HOLD;
                        ir_q       <= imem_rdata_i;
                        ir_valid_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (pc_write_i) begin
`ifdef FETCH_MISALIGN_CHK_EN
                        if (misalign_err_q) begin
                            // Parked: only an aligned trap redirect restarts fetching
                            if (trap_src_d && !misaligned_d) begin
                                pc_q           <= next_pc_d;
                                misalign_err_q <= 1'b0;
                                state_q        <= S_REQ;
                                imem_req_q     <= 1'b1;
                            end
                        end else if (misaligned_d) begin
                            pc_q           <= next_pc_d;
                            misalign_err_q <= 1'b1;
                            ir_valid_q     <= 1'b0;
                        end else begin
                            pc_q       <= next_pc_d;
                            ir_valid_q <= 1'b0;
                            state_q    <= S_REQ;
                            imem_req_q <= 1'b1;
                        end
`else
                        pc_q       <= next_pc_d;
                        ir_valid_q <= 1'b0;
                        state_q    <= S_REQ;
                        imem_req_q <= 1'b1;
`endif
                    end
                end
                default: begin
                    state_q    <= S_BOOT;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o  = imem_req_q;
    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_plus4_d;
    assign ir_o        = ir_q;
    assign ir_valid_o  = ir_valid_q;

endmodule
